// File: rtl/ones_count_accumulator_if.sv
// Handshake bundle between the popcount producer, the frame accumulator and the result consumer.
// The producer/consumer side uses the master modport; the accumulator uses the slave modport.
interface ones_count_accumulator_if #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 10
);
    localparam int WC_W = $clog2(FRAME_LEN + 1);

    logic [6:0]       cnt_in;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             flush;
    logic [ACC_W-1:0] sum_out;
    logic [WC_W-1:0]  word_cnt;
    logic             above_thr;
    logic             overflow;
    logic             sum_valid;
    logic             sum_ready;

    modport master (
        output cnt_in, cnt_valid, flush, sum_ready,
        input  cnt_ready, sum_out, word_cnt, above_thr, overflow, sum_valid
    );

    modport slave (
        input  cnt_in, cnt_valid, flush, sum_ready,
        output cnt_ready, sum_out, word_cnt, above_thr, overflow, sum_valid
    );
endinterface

// File: rtl/ones_count_accumulator.sv
// Sums per-word popcounts over a frame of FRAME_LEN words (or until flush) and holds the
// saturating total with threshold/overflow flags until the consumer takes it.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_ACCUM | accepting counts into the accumulator, cnt_ready=1
// ST_HOLD  | frame result presented (sum_valid=1), waiting for sum_ready
module ones_count_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 10,
    parameter int THRESHOLD = 508
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ones_count_accumulator_if.slave  bus
);
    localparam int WC_W = $clog2(FRAME_LEN + 1);
    localparam logic [WC_W-1:0]  FRAME_LEN_W = WC_W'(FRAME_LEN);
    localparam logic [ACC_W:0]   THR_EXT     = (ACC_W + 1)'(THRESHOLD);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [WC_W-1:0]  r_words;
    logic             r_ovf;
    logic [ACC_W-1:0] r_sum_out;
    logic [WC_W-1:0]  r_word_cnt;
    logic             r_above;
    logic             r_ovf_out;

    state_t           w_state_next;
    logic [ACC_W-1:0] w_acc_next;
    logic [WC_W-1:0]  w_words_next;
    logic             w_ovf_next;
    logic             w_close;
    logic             w_above_next;
    logic [ACC_W:0]   w_sum_ext;
    logic             w_carry;

    // One extra bit on the adder exposes the carry-out used for saturation.
    assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W - 6){1'b0}}, bus.cnt_in};
    assign w_carry   = w_sum_ext[ACC_W];

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_words_next = r_words;
        w_ovf_next   = r_ovf;
        w_close      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (bus.cnt_valid) begin
                    w_acc_next   = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
                    w_words_next = r_words + WC_W'(1);
                    w_ovf_next   = r_ovf | w_carry;
                end
                // A word accepted together with flush belongs to the closing frame.
                if ((bus.cnt_valid && (w_words_next == FRAME_LEN_W)) ||
                    (bus.flush && (w_words_next != '0))) begin
                    w_close      = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.sum_ready) begin
                    w_acc_next   = '0;
                    w_words_next = '0;
                    w_ovf_next   = 1'b0;
                    w_state_next = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    assign w_above_next = ({1'b0, w_acc_next} >= THR_EXT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_words    <= '0;
            r_ovf      <= 1'b0;
            r_sum_out  <= '0;
            r_word_cnt <= '0;
            r_above    <= 1'b0;
            r_ovf_out  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_words <= w_words_next;
            r_ovf   <= w_ovf_next;
            if (w_close) begin
                r_sum_out  <= w_acc_next;
                r_word_cnt <= w_words_next;
                r_above    <= w_above_next;
                r_ovf_out  <= w_ovf_next;
            end
        end
    end

    assign bus.cnt_ready = (r_state == ST_ACCUM);
    assign bus.sum_valid = (r_state == ST_HOLD);
    assign bus.sum_out   = r_sum_out;
    assign bus.word_cnt  = r_word_cnt;
    assign bus.above_thr = r_above;
    assign bus.overflow  = r_ovf_out;
endmodule
